pipelined_rca_adder: RTL
========================

// Module: pipelined_rca_adder
// PURPOSE
//   Parametrised, pipelined ripple-carry add/subtract unit; successor to the fixed 4-bit combinational adder.
//   Splits a WIDTH-bit operation into STAGES slices. Each slice is a ripple chain of FullAdder cells with a
//   registered carry between slices, so the design runs at one result per clock. Sits between operand
//   producers and the ALU/accumulator datapath, with valid/ready flow control on both sides.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline depth = number of carry-registered slices (1..WIDTH); SLICE = WIDTH/STAGES
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand transfer request
//   in_ready   out  1      unit can accept operands this cycle
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   c_in       in   1      carry-in (ignored when sub=1)
//   sub        in   1      0: A+B+c_in; 1: A-B (A + ~B + 1)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   S          out  WIDTH  sum/difference
//   c_out      out  1      carry out of MSB (for sub: 1 = no borrow)
// BEHAVIOUR
//   - Reset (async, rst_n=0): all stage valids, carries, partial sums, S, c_out, out_valid -> 0; in_ready=1 after reset.
//   - Global advance: adv = !out_valid | out_ready. When adv=1 every stage shifts one step; when 0 the whole pipe holds.
//   - in_ready = adv (combinational). Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
//   - Stage 0 latches A, B' = sub ? ~B : B, and cin0 = sub ? 1 : c_in; computes slice 0 with a ripple chain.
//   - Stage k computes bits [k*SLICE +: SLICE] from the registered carry of stage k-1. Skew: upper operand
//     bits travel with the token; lower result bits are delayed so all S bits emerge aligned.
//   - Latency: exactly STAGES cycles from input transfer to out_valid, when there is no stall. Throughput: 1 per cycle.
//   - Bubbles: a stage whose valid=0 still shifts, so bubbles collapse only via flow, not by compaction. The valid bit
//     travels with its data.
//   - Stall with out_valid=1 & out_ready=0: S, c_out and out_valid hold stable; in_ready=0.
//   - Arithmetic is modulo 2^WIDTH; c_out is the true carry out of bit WIDTH-1. STAGES=1 degenerates to one registered
//     ripple adder with latency 1.
//   - Reset asserted mid-operation: all in-flight tokens are discarded; no partial result is ever presented.
//   - out_valid=0 => S and c_out hold their last values (0 after reset); consumers must qualify on out_valid.
// CONFIGURATION
//   OVERFLOW_FLAG_EN defined: extra output port `ovf` (out, 1). It is the signed overflow of the final slice MSB
//     (carry into MSB XOR carry out), aligned with S, reset to 0, and held on stall.
//   OVERFLOW_FLAG_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.
// TESTING (WIDTH=16, STAGES=4 unless noted)
//   1 Reset: rst_n=0 mid-stream with 3 tokens in flight -> out_valid=0, S=0, c_out=0 immediately; no stale output after release.
//   2 Add: A=16'hFFFF, B=16'h0001, c_in=0, sub=0 -> 4 cycles later S=16'h0000, c_out=1 (full carry ripple across all slices).
//   3 Sub: A=16'h0005, B=16'h0007, sub=1 -> S=16'hFFFE, c_out=0; with OVERFLOW_FLAG_EN, 16'h7FFF+16'h0001 gives ovf=1.
//   4 Back-to-back: 100 random ops, in_valid=1 and out_ready=1 throughout -> one result per cycle, in order, matching a reference model.
//   5 Backpressure: out_ready toggled randomly (50%) -> no result lost or duplicated, S stable while stalled, in_ready=0 while stalled.
//   6 Params: STAGES=1 and STAGES=WIDTH=8 -> latency 1 and 8 respectively; 8'hFF+8'hFF+c_in=1 -> S=8'hFF, c_out=1.

Source files
------------

// File: rtl/pipelined_rca_adder_if.sv
// rtl/pipelined_rca_adder_if.sv - operand/result handshake bundle for pipelined_rca_adder
// OVERFLOW_FLAG_EN adds the ovf result flag to the bundle.
interface pipelined_rca_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             c_out;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, A, B, c_in, sub, out_ready,
        input  in_ready, out_valid, S, c_out
`ifdef OVERFLOW_FLAG_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, A, B, c_in, sub, out_ready,
        output in_ready, out_valid, S, c_out
`ifdef OVERFLOW_FLAG_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_rca_adder.sv
// rtl/pipelined_rca_adder.sv - pipelined ripple-carry add/subtract, one result per clock
// Optional OVERFLOW_FLAG_EN adds a registered signed-overflow flag aligned with S.
module pipelined_rca_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_rca_adder_if.slave bus
);
    localparam int SLICE = WIDTH / STAGES;

    logic w_adv;

    assign w_adv         = !g_stage[STAGES-1].r_vld || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = g_stage[STAGES-1].r_vld;
    assign bus.S         = g_stage[STAGES-1].r_s;
    assign bus.c_out     = g_stage[STAGES-1].r_cy;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             r_vld;
        logic             r_cy;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_s;

        logic             w_vi;
        logic             w_ci;
        logic [WIDTH-1:0] w_ai;
        logic [WIDTH-1:0] w_bi;
        logic [WIDTH-1:0] w_si;
        logic [WIDTH-1:0] w_s_next;
        logic [SLICE:0]   w_c;
        logic [SLICE-1:0] w_sum;

        if (k == 0) begin : g_head
            assign w_vi = bus.in_valid;
            assign w_ai = bus.A;
            assign w_bi = bus.sub ? ~bus.B : bus.B;
            assign w_ci = bus.sub ? 1'b1 : bus.c_in;
            assign w_si = '0;
        end else begin : g_body
            assign w_vi = g_stage[k-1].r_vld;
            assign w_ai = g_stage[k-1].r_a;
            assign w_bi = g_stage[k-1].r_b;
            assign w_ci = g_stage[k-1].r_cy;
            assign w_si = g_stage[k-1].r_s;
        end

        assign w_c[0] = w_ci;
        for (genvar j = 0; j < SLICE; j++) begin : g_fa
            localparam int BIT = k * SLICE + j;
            assign w_sum[j]   = w_ai[BIT] ^ w_bi[BIT] ^ w_c[j];
            assign w_c[j+1]   = (w_ai[BIT] & w_bi[BIT]) | (w_c[j] & (w_ai[BIT] ^ w_bi[BIT]));
        end

        // Lower result bits ride along from earlier stages; this stage fills in its own slice.
        always_comb begin
            w_s_next                    = w_si;
            w_s_next[k*SLICE +: SLICE]  = w_sum;
        end

        // Data only loads with a valid token so a bubble never disturbs the held result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_cy  <= 1'b0;
                r_a   <= '0;
                r_b   <= '0;
                r_s   <= '0;
            end else if (w_adv) begin
                r_vld <= w_vi;
                if (w_vi) begin
                    r_cy <= w_c[SLICE];
                    r_a  <= w_ai;
                    r_b  <= w_bi;
                    r_s  <= w_s_next;
                end
            end
        end

`ifdef OVERFLOW_FLAG_EN
        if (k == STAGES - 1) begin : g_ovf
            logic r_ovf;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv && w_vi) begin
                    r_ovf <= w_c[SLICE-1] ^ w_c[SLICE];
                end
            end
        end
`endif
    end

`ifdef OVERFLOW_FLAG_EN
    assign bus.ovf = g_stage[STAGES-1].g_ovf.r_ovf;
`endif
endmodule
